// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared LCD colour, pattern and geometry definitions
package lcd_pkg;

  localparam int H_RES_DEF = 320;
  localparam int V_RES_DEF = 240;

  localparam logic [15:0] RGB_RED   = 16'hF800;
  localparam logic [15:0] RGB_GREEN = 16'h07E0;
  localparam logic [15:0] RGB_BLUE  = 16'h001F;
  localparam logic [15:0] RGB_BLACK = 16'h0000;

  localparam logic [1:0] PAT_GRID   = 2'd0;
  localparam logic [1:0] PAT_BARS   = 2'd1;
  localparam logic [1:0] PAT_GRAD   = 2'd2;
  localparam logic [1:0] PAT_SCROLL = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_TE = 2'd1,
    ST_STREAM  = 2'd2
  } src_state_t;

endpackage

// File: rtl/lcd_te_sync.sv
// rtl/lcd_te_sync.sv - tearing-effect synchronizer with one-cycle rising-edge pulse
module lcd_te_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_fmark,
  output logic o_te_pulse
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_fmark};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_te_pulse = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/lcd_pixel_source.sv
// rtl/lcd_pixel_source.sv - TE-synced RGB565 test-pattern frame source for the 8080 write engine
module lcd_pixel_source
  import lcd_pkg::*;
#(
  parameter int H_RES       = H_RES_DEF,
  parameter int V_RES       = V_RES_DEF,
  parameter int BORDER      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_init_done,
  input  logic        i_lcd_fmark,
  input  logic [1:0]  i_pattern,
  input  logic        i_pix_ready,
  output logic [15:0] o_pix_data,
  output logic        o_pix_valid,
  output logic        o_pix_sof,
  output logic        o_pix_last,
  output logic [7:0]  o_frame_count,
  output logic        o_te_missed
);

  src_state_t  r_state, w_state_nx;
  logic [8:0]  r_x, w_nx;
  logic [7:0]  r_y, w_ny;
  logic [1:0]  r_pat;
  logic [15:0] r_data;
  logic        r_valid, r_sof, r_last, r_te_missed;
  logic [7:0]  r_fc;
  logic        w_te, w_xfer, w_start, w_adv, w_end, w_nlast;

  function automatic logic [15:0] pix_f(input logic [1:0] pat, input logic [8:0] x,
                                        input logic [7:0] y, input logic [7:0] fc);
    logic [8:0]  gx;
    logic [2:0]  bar;
    logic [15:0] f;
    // scroll pattern shifts only the grid columns; the red band is row based
    gx  = (pat == PAT_SCROLL) ? 9'((10'(x) + 10'(fc)) % 10'(H_RES)) : x;
    bar = 3'((12'(x) * 12'd8) / 12'(H_RES));
    case (pat)
      PAT_BARS: f = {{5{bar[2]}}, {6{bar[1]}}, {5{bar[0]}}};
      PAT_GRAD: f = {x[8:4], y[7:2], ~x[8:4]};
      default: begin
        if (32'(y) < 32'(BORDER))  f = RGB_RED;
        else if (y[3:0] == 4'd0)   f = RGB_BLUE;
        else if (gx[3:0] == 4'd0)  f = RGB_GREEN;
        else                       f = RGB_BLACK;
      end
    endcase
    return f;
  endfunction

  lcd_te_sync #(.SYNC_STAGES(SYNC_STAGES)) u_te_sync (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_fmark    (i_lcd_fmark),
    .o_te_pulse (w_te)
  );

  assign w_xfer  = r_valid & i_pix_ready;
  assign w_nx    = (r_x == 9'(H_RES - 1)) ? 9'd0 : r_x + 9'd1;
  assign w_ny    = (r_x == 9'(H_RES - 1)) ? r_y + 8'd1 : r_y;
  assign w_nlast = (w_nx == 9'(H_RES - 1)) && (w_ny == 8'(V_RES - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_start    = 1'b0;
    w_adv      = 1'b0;
    w_end      = 1'b0;
    case (r_state)
      ST_IDLE:    if (i_init_done) w_state_nx = ST_WAIT_TE;
      ST_WAIT_TE: if (w_te) begin
        w_start    = 1'b1;
        w_state_nx = ST_STREAM;
      end
      ST_STREAM:  if (w_xfer) begin
        if (r_last) begin
          w_end      = 1'b1;
          w_state_nx = ST_WAIT_TE;
        end else begin
          w_adv = 1'b1;
        end
      end
      default:    w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_x         <= '0;
      r_y         <= '0;
      r_pat       <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_sof       <= 1'b0;
      r_last      <= 1'b0;
      r_fc        <= '0;
      r_te_missed <= 1'b0;
    end else begin
      if (w_te && r_state == ST_STREAM) r_te_missed <= 1'b1;
      if (w_start) begin
        r_pat   <= i_pattern;
        r_x     <= '0;
        r_y     <= '0;
        r_data  <= pix_f(i_pattern, 9'd0, 8'd0, r_fc);
        r_valid <= 1'b1;
        r_sof   <= 1'b1;
        r_last  <= 1'b0;
      end else if (w_end) begin
        r_valid <= 1'b0;
        r_sof   <= 1'b0;
        r_last  <= 1'b0;
        r_fc    <= r_fc + 8'd1;
      end else if (w_adv) begin
        r_x    <= w_nx;
        r_y    <= w_ny;
        r_data <= pix_f(r_pat, w_nx, w_ny, r_fc);
        r_sof  <= 1'b0;
        r_last <= w_nlast;
      end
    end
  end

  assign o_pix_data    = r_data;
  assign o_pix_valid   = r_valid;
  assign o_pix_sof     = r_sof;
  assign o_pix_last    = r_last;
  assign o_frame_count = r_fc;
  assign o_te_missed   = r_te_missed;

endmodule
